// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: bus widths, the zero word,
// stall encodings and the bit positions inside the ctrl stall vector.
package if_id_queue_pkg;

  localparam int InstAddrBus = 32;          // default PC width
  localparam int InstBus     = 32;          // default instruction width

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Positions in the 6-bit ctrl stall vector
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

endpackage

// File: rtl/if_id_queue_inst_fifo.sv
// inst_fifo: small synchronous FIFO holding {pc, inst} pairs.
// clear has priority over push/pop. A push while full and a pop while empty
// are ignored. The head entry is read combinationally so the caller can load
// it into its own output register on the same edge that pops it.
module inst_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID pipeline register with a DEPTH-entry instruction queue.
// Fetch pushes with a valid/ready handshake; decode consumes whenever
// stall[STALL_ID] is clear. An empty queue lets a fetched instruction bypass
// straight into the output register (1-cycle latency, like the old register).
// Optional build macro IF_ID_QUEUE_PERF_EN adds bubble_cnt / full_cnt.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       full_cnt
`endif
);

  localparam int W = ADDR_W + INST_W;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [W-1:0]          head;
  logic                  enq;
  logic                  adv;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  bubble;
  logic                  unused_bits;

  // Only the ID stall bit matters here; fetch back-pressure is if_ready.
  assign unused_bits = ^{stall[5:3], stall[STALL_IF], stall[0], fifo_count};

  assign if_ready  = ~fifo_full;
  assign enq       = if_valid & if_ready;
  assign adv       = (stall[STALL_ID] == NoStop);
  // Bypass case (advance with empty queue) must not also write the queue.
  assign fifo_push = enq & ~flush & ~(adv & fifo_empty);
  assign fifo_pop  = adv & ~fifo_empty & ~flush;
  assign bubble    = adv & fifo_empty & ~enq & ~flush;

  inst_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .din   ({if_pc, if_inst}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output register: flush > head load > bypass > bubble; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= INST_W'(ZeroWord);
    end else if (flush) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= INST_W'(ZeroWord);
    end else if (adv) begin
      if (!fifo_empty) begin
        id_valid <= 1'b1;
        id_pc    <= head[W-1:INST_W];
        id_inst  <= head[INST_W-1:0];
      end else if (enq) begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
      end else begin
        id_valid <= 1'b0;
        id_pc    <= '0;
        id_inst  <= INST_W'(ZeroWord);
      end
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  // Saturating event counters; flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      full_cnt   <= '0;
    end else begin
      if (bubble && bubble_cnt != '1)                full_cnt <= full_cnt;
      if (bubble && bubble_cnt != '1)                bubble_cnt <= bubble_cnt + 32'd1;
      if (if_valid && !if_ready && full_cnt != '1)   full_cnt <= full_cnt + 32'd1;
    end
  end
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed steps then a randomized run,
// all compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: accepted-instruction queue plus the presented instruction.
  logic [63:0] mq[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ".id_pc"},    id_pc,   m_pc);
    chk({tag, ".id_inst"},  id_inst, m_inst);
  endtask

  // One clock of stimulus: drive, check if_ready before the edge, update model.
  task automatic cycle(input string tag, input logic st, input logic fl,
                       input logic v, input logic [31:0] pc, input logic [31:0] inst);
    logic        enq;
    logic [5:0]  other;
    other    = 6'($urandom_range(0, 63)) & 6'b111011;
    stall    = other | {3'b000, st, 2'b00};
    flush    = fl;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    #1;
    chk({tag, ".if_ready"}, {31'd0, if_ready}, {31'd0, (mq.size() < DEPTH)});
    enq = v && (mq.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_valid = 1'b0; m_pc = '0; m_inst = '0;
    end else if (!st) begin
      if (mq.size() > 0) begin
        {m_pc, m_inst} = mq.pop_front();
        m_valid = 1'b1;
        if (enq) mq.push_back({pc, inst});
      end else if (enq) begin
        m_valid = 1'b1; m_pc = pc; m_inst = inst;
      end else begin
        m_valid = 1'b0; m_pc = '0; m_inst = '0;
      end
    end else if (enq) begin
      mq.push_back({pc, inst});
    end
    #1;
    chk_out(tag);
    $display("cyc %s st=%0b fl=%0b v=%0b pc=%h -> id_valid=%0b id_pc=%h id_inst=%h q=%0d",
             tag, st, fl, v, pc, id_valid, id_pc, id_inst, mq.size());
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_pc = '0; m_inst = '0;
  endtask

  initial begin
    logic        r_st, r_fl, r_v;
    logic [31:0] r_pc;
    rst = 1'b1; stall = '0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    model_reset();
    #2;
    chk_out("reset");
    chk("reset.if_ready", {31'd0, if_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Bypass latency, then a bubble
    cycle("bypass", 1'b0, 1'b0, 1'b1, 32'h100, 32'h34010001);
    cycle("bubble", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fill under stall, 5th push refused
    for (int i = 0; i < 4; i++)
      cycle("fill", 1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i));
    cycle("full_push", 1'b1, 1'b0, 1'b1, 32'h110, 32'hA004);
    chk("full.if_ready", {31'd0, if_ready}, 32'd0);

    // Drain in order, then empty
    for (int i = 0; i < 5; i++)
      cycle("drain", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Hold two entries, then push+advance across the pointer wrap
    cycle("pre", 1'b1, 1'b0, 1'b1, 32'h200, 32'hB000);
    cycle("pre", 1'b1, 1'b0, 1'b1, 32'h204, 32'hB001);
    for (int i = 0; i < 10; i++)
      cycle("wrap", 1'b0, 1'b0, 1'b1, 32'h208 + 32'(4 * i), 32'hB002 + 32'(i));

    // Async reset mid-stream with two entries queued
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_out("async_rst");
    chk("async_rst.if_ready", {31'd0, if_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Flush with three queued and a concurrent push, then bypass again
    for (int i = 0; i < 3; i++)
      cycle("preflush", 1'b1, 1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'hC000 + 32'(i));
    cycle("flush", 1'b0, 1'b1, 1'b1, 32'h30C, 32'hC003);
    cycle("post_flush", 1'b0, 1'b0, 1'b1, 32'h400, 32'hD000);
    cycle("post_flush2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic
    r_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      r_st = ($urandom_range(0, 99) < 45);
      r_fl = ($urandom_range(0, 99) < 4);
      r_v  = ($urandom_range(0, 99) < 70);
      cycle("rand", r_st, r_fl, r_v, r_pc, $urandom);
      r_pc = r_pc + 32'd4;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
